// File: rtl/shift_register_unit.sv
// Universal WIDTH-bit shift register for the serial adder datapath: parallel
// load, LSB-first shift/rotate right, wrapping shift counter and sticky done.
module shift_register_unit #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CW          = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic [CW-1:0]    count,
    output logic             done
);

    localparam logic [1:0] MODE_HOLD     = 2'b00;
    localparam logic [1:0] MODE_LOAD     = 2'b01;
    localparam logic [1:0] MODE_SHIFT_R  = 2'b10;
    localparam logic [1:0] MODE_ROTATE_R = 2'b11;

    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("shift_register_unit: WIDTH must be in 2..32");
        end
    endgenerate

    // Bit entering the MSB: external serial data when shifting, own LSB when rotating.
    logic fill_bit;
    assign fill_bit = (mode == MODE_SHIFT_R) ? serial_in : q[0];

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, as real flops do.
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= RESET_VALUE;
            count <= '0;
            done  <= 1'b0;
        end else if (enable) begin
            case (mode)
                MODE_LOAD: begin
                    q     <= d;
                    count <= '0;
                    done  <= 1'b0;
                end
                MODE_SHIFT_R, MODE_ROTATE_R: begin
                    q <= {fill_bit, q[WIDTH-1:1]};
                    // The WIDTH-th shift wraps the counter and latches done.
                    if (count == LAST_COUNT) begin
                        count <= '0;
                        done  <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                MODE_HOLD: ;
                default: ;  // unknown mode behaves as HOLD
            endcase
        end
    end

    assign serial_out = q[0];

    // An unknown mode while enabled is a usage error; the datapath holds.
    mode_known_chk: assert property (@(posedge clk) (!reset && enable) |-> !$isunknown(mode))
        else $warning("shift_register_unit: unknown mode %b while enabled, treated as HOLD", mode);

endmodule
